// File: rtl/mem_bus_if.sv
// mem_bus_if: CPU request/response side and AHB-lite master side of the memory bus controller.
interface mem_bus_if;
   logic        cpu_en, flush, req_valid, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_stall, rdata_valid, exp_misalign, exp_bus_err;
   logic [31:0] rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite, hready, hresp;
   modport master (
      input  cpu_en, flush, req_valid, req_write, req_unsigned, req_size, req_addr, req_wdata,
      input  hrdata, hready, hresp,
      output mem_stall, rdata_valid, exp_misalign, exp_bus_err, rdata,
      output haddr, hwdata, htrans, hsize, hwrite
   );
   modport slave (
      output cpu_en, flush, req_valid, req_write, req_unsigned, req_size, req_addr, req_wdata,
      output hrdata, hready, hresp,
      input  mem_stall, rdata_valid, exp_misalign, exp_bus_err, rdata,
      input  haddr, hwdata, htrans, hsize, hwrite
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding AHB-lite load/store controller for the MEM stage,
// with lane replication on stores and byte/half extraction plus extension on loads.
module mem_bus_ctrl (
   input logic       clk,
   input logic       rst_n,
   mem_bus_if.master bus
);
   localparam logic [1:0] IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10;
   logic [1:0]  state, next_state, size_q;
   logic [31:0] addr_q, wdata_q, rep, ld;
   logic        write_q, uns_q, aligned, req, accept, done;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   always_comb begin
      aligned = bus.req_size == 2'b00 || (bus.req_size == 2'b01 && !bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] == 2'b00);
      req = rst_n && state == IDLE && bus.req_valid && bus.cpu_en && !bus.flush;
      accept = req && aligned;
      done = state == DATA && bus.hready;
      rep = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
            bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
      next_state = state == IDLE ? (accept ? ADDR : IDLE) :
                   state == ADDR ? (bus.hready ? DATA : ADDR) :
                   state == DATA ? (bus.hready ? IDLE : DATA) : IDLE;
      lane_b = bus.hrdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? bus.hrdata[31:16] : bus.hrdata[15:0];
      ld = size_q == 2'b00 ? {{24{lane_b[7] & !uns_q}}, lane_b} :
           size_q == 2'b01 ? {{16{lane_h[15] & !uns_q}}, lane_h} : bus.hrdata;
   end
   // Address/control and write data come straight from registers, so reset clears them at once.
   assign bus.htrans       = state == ADDR ? 2'b10 : 2'b00;
   assign bus.haddr        = addr_q;
   assign bus.hwrite       = write_q;
   assign bus.hsize        = {1'b0, size_q};
   assign bus.hwdata       = wdata_q;
   assign bus.mem_stall    = accept || state == ADDR || (state == DATA && !bus.hready);
   assign bus.exp_misalign = req && !aligned;
   assign bus.exp_bus_err  = done && bus.hresp;
   assign bus.rdata_valid  = done && !bus.hresp && !write_q;
   assign bus.rdata        = bus.rdata_valid ? ld : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= rep;
            size_q  <= bus.req_size;
            write_q <= bus.req_write;
            uns_q   <= bus.req_unsigned;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven and randomized checks of mem_bus_ctrl against a
// transaction-level model of alignment, lane replication and load extension.
module tb_mem_bus_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   mem_bus_if bus ();
   mem_bus_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      bit          en, flush, write;
      bit [1:0]    size;
      bit          uns;
      bit [31:0]   addr, wdata, hrdata;
      int          wa, wd;
      bit          err, acc, mis;
      bit [31:0]   rd, hw;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit aligned_m(input bit [1:0] sz, input bit [31:0] a);
      return sz != 2'd3 && (a % (32'd1 << sz)) == 0;
   endfunction

   function automatic bit [31:0] load_m(input bit [1:0] sz, input bit u, input bit [31:0] a, input bit [31:0] d);
      int bits;
      bit [31:0] mask, v;
      if (sz == 2'd2) return d;
      bits = 8 << sz;
      mask = 32'((64'd1 << bits) - 1);
      v = (d >> (8 * a[1:0])) & mask;
      if (!u && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit [31:0] store_m(input bit [1:0] sz, input bit [31:0] w);
      if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered just after a clock edge with the controller idle; leaves it idle the same way.
   task automatic do_txn(input vec_t v);
      bus.cpu_en = v.en; bus.flush = v.flush; bus.req_valid = 1'b1;
      bus.req_write = v.write; bus.req_size = v.size; bus.req_unsigned = v.uns;
      bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.hrdata = v.hrdata;
      bus.hready = 1'b1; bus.hresp = 1'b0;
      @(negedge clk);
      chk("stall_accept", bus.mem_stall, v.acc);
      chk("misalign", bus.exp_misalign, v.mis);
      chk("htrans_idle", bus.htrans, 2'b00);
      step();
      bus.req_valid = 1'b0;
      bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_size = 2'($urandom);
      bus.req_write = 1'($urandom); bus.req_unsigned = 1'($urandom);
      bus.cpu_en = 1'($urandom); bus.flush = 1'($urandom);
      if (!v.acc) begin
         @(negedge clk);
         chk("no_xfer_htrans", bus.htrans, 2'b00);
         chk("no_xfer_stall", bus.mem_stall, 1'b0);
         step();
         return;
      end
      for (int i = 0; i <= v.wa; i++) begin
         bus.hready = (i == v.wa);
         @(negedge clk);
         chk("addr_htrans", bus.htrans, 2'b10);
         chk("addr_haddr", bus.haddr, v.addr);
         chk("addr_hsize", bus.hsize, {1'b0, v.size});
         chk("addr_hwrite", bus.hwrite, v.write);
         chk("addr_stall", bus.mem_stall, 1'b1);
         step();
      end
      for (int i = 0; i < v.wd; i++) begin
         bus.hready = 1'b0;
         bus.hresp = v.err ? 1'($urandom) : 1'b0;
         @(negedge clk);
         chk("wait_htrans", bus.htrans, 2'b00);
         chk("wait_stall", bus.mem_stall, 1'b1);
         chk("wait_rvalid", bus.rdata_valid, 1'b0);
         chk("wait_buserr", bus.exp_bus_err, 1'b0);
         if (v.write) chk("wait_hwdata", bus.hwdata, v.hw);
         step();
      end
      bus.hready = 1'b1;
      bus.hresp = v.err;
      @(negedge clk);
      chk("done_stall", bus.mem_stall, 1'b0);
      chk("done_htrans", bus.htrans, 2'b00);
      chk("done_rvalid", bus.rdata_valid, !v.write && !v.err);
      chk("done_rdata", bus.rdata, (!v.write && !v.err) ? v.rd : 32'd0);
      chk("done_buserr", bus.exp_bus_err, v.err);
      if (v.write) chk("done_hwdata", bus.hwdata, v.hw);
      step();
      bus.hresp = 1'b0;
      @(negedge clk);
      chk("after_buserr", bus.exp_bus_err, 1'b0);
      chk("after_rvalid", bus.rdata_valid, 1'b0);
      chk("after_htrans", bus.htrans, 2'b00);
      step();
   endtask

   vec_t tbl[11];
   vec_t v;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      //         en flush wr size uns addr          wdata         hrdata        wa wd err acc mis rd            hw
      tbl[0]  = '{1, 0, 0, 2'd2, 0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1, 0, 0, 2'd0, 0, 32'h0000_0103, 32'h0,        32'h80112233, 0, 0, 0, 1, 0, 32'hFFFFFF80, 32'h0};
      tbl[2]  = '{1, 0, 0, 2'd0, 1, 32'h0000_0103, 32'h0,        32'h80112233, 0, 0, 0, 1, 0, 32'h00000080, 32'h0};
      tbl[3]  = '{1, 0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000ABCD, 32'h0,        0, 3, 0, 1, 0, 32'h0,        32'hABCDABCD};
      tbl[4]  = '{1, 0, 0, 2'd2, 0, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0};
      tbl[5]  = '{1, 1, 0, 2'd2, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0};
      tbl[6]  = '{1, 0, 0, 2'd2, 0, 32'h0000_0300, 32'h0,        32'h12345678, 0, 1, 1, 1, 0, 32'h0,        32'h0};
      tbl[7]  = '{1, 0, 0, 2'd1, 0, 32'h0000_0106, 32'h0,        32'h80017FFF, 2, 0, 0, 1, 0, 32'hFFFF8001, 32'h0};
      tbl[8]  = '{1, 0, 1, 2'd0, 0, 32'h0000_0101, 32'h123456A5, 32'h0,        1, 2, 0, 1, 0, 32'h0,        32'hA5A5A5A5};
      tbl[9]  = '{0, 0, 0, 2'd2, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0};
      tbl[10] = '{1, 0, 0, 2'd3, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0};

      bus.cpu_en = 1'b1; bus.flush = 1'b0; bus.req_valid = 1'b1; bus.req_write = 1'b0;
      bus.req_size = 2'd2; bus.req_unsigned = 1'b0; bus.req_addr = 32'h102; bus.req_wdata = 32'h0;
      bus.hrdata = 32'hFFFFFFFF; bus.hready = 1'b1; bus.hresp = 1'b1;
      @(negedge clk);
      chk("rst_htrans", bus.htrans, 2'b00);
      chk("rst_haddr", bus.haddr, 32'd0);
      chk("rst_hsize", bus.hsize, 3'd0);
      chk("rst_hwdata", bus.hwdata, 32'd0);
      chk("rst_stall", bus.mem_stall, 1'b0);
      chk("rst_misalign", bus.exp_misalign, 1'b0);
      chk("rst_buserr", bus.exp_bus_err, 1'b0);
      chk("rst_rvalid", bus.rdata_valid, 1'b0);
      chk("rst_rdata", bus.rdata, 32'd0);
      bus.req_valid = 1'b0; bus.hresp = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      foreach (tbl[i]) do_txn(tbl[i]);

      // Reset in the middle of an address phase abandons the transfer silently.
      bus.cpu_en = 1'b1; bus.flush = 1'b0; bus.req_valid = 1'b1; bus.req_write = 1'b0;
      bus.req_size = 2'd2; bus.req_addr = 32'h0000_0400; bus.hready = 1'b0; bus.hresp = 1'b0;
      step();
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_htrans", bus.htrans, 2'b10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_htrans", bus.htrans, 2'b00);
      chk("midrst_haddr", bus.haddr, 32'd0);
      chk("midrst_stall", bus.mem_stall, 1'b0);
      bus.hready = 1'b1; bus.hresp = 1'b1;
      @(negedge clk);
      chk("midrst_buserr", bus.exp_bus_err, 1'b0);
      chk("midrst_rvalid", bus.rdata_valid, 1'b0);
      bus.hresp = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_htrans", bus.htrans, 2'b00);
      chk("post_rst_stall", bus.mem_stall, 1'b0);
      step();

      for (int n = 0; n < 60; n++) begin
         v.en = ($urandom_range(0, 9) != 0);
         v.flush = ($urandom_range(0, 7) == 0);
         v.write = 1'($urandom);
         v.size = 2'($urandom_range(0, 3));
         v.uns = 1'($urandom);
         v.addr = $urandom;
         if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'd1 << v.size) - 1);
         v.wdata = $urandom;
         v.hrdata = $urandom;
         v.wa = $urandom_range(0, 2);
         v.wd = $urandom_range(0, 3);
         v.err = ($urandom_range(0, 7) == 0);
         v.acc = v.en && !v.flush && aligned_m(v.size, v.addr);
         v.mis = v.en && !v.flush && !aligned_m(v.size, v.addr);
         v.rd = load_m(v.size, v.uns, v.addr, v.hrdata);
         v.hw = store_m(v.size, v.wdata);
         do_txn(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have ports clk (input, 1) and rst_n (input, 1); reset rst_n is asynchronous, active-low; clock clk.
REQ-002 SHALL have cpu_en (input, 1): global run enable; when low, no new request is accepted.
REQ-003 SHALL have flush (input, 1): cancels a request presented in IDLE.
REQ-004 SHALL have req_valid (input, 1): memory access requested by the EX stage.
REQ-005 SHALL have req_write (input, 1): 1 = store, 0 = load.
REQ-006 SHALL have req_size (input, 2): 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have req_unsigned (input, 1): load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have req_addr (input, 32) and req_wdata (input, 32): byte address and store data, with store data right-aligned.
REQ-009 SHALL have mem_stall (output, 1): pipeline stall request to the MEM register.
REQ-010 SHALL have rdata (output, 32) and rdata_valid (output, 1): extended load result and its qualifier.
REQ-011 SHALL have exp_misalign (output, 1) and exp_bus_err (output, 1): one-cycle exception pulses.
REQ-012 SHALL have AHB-lite master outputs haddr (32), htrans (2), hwrite (1), hsize (3) and hwdata (32).
REQ-013 SHALL have AHB-lite master inputs hrdata (32), hready (1) and hresp (1).

Function
REQ-014 SHALL implement the FSM states IDLE, ADDR and DATA, with one transfer outstanding at most.
REQ-015 SHALL accept a request in IDLE when req_valid && cpu_en && !flush && aligned.
- aligned: size 00, or size 01 with addr[0]=0, or size 10 with addr[1:0]=00.
REQ-016 On accept, SHALL register address, write, size, unsigned, addr[1:0] and lane-replicated wdata, then move IDLE->ADDR.
- Lane replication: byte copied to all 4 lanes; half copied to both halves.
REQ-017 In ADDR, SHALL drive htrans=NONSEQ (10), haddr=registered address, hsize={0,size} and hwrite.
- SHALL hold these while hready=0.
- SHALL move ADDR->DATA on hready=1.
REQ-018 In DATA, SHALL drive htrans=IDLE (00) and hwdata=registered write data.
- SHALL hold both until hready=1, then return to IDLE.
REQ-019 In IDLE and DATA, SHALL drive htrans=00.
REQ-020 In IDLE, mem_stall SHALL equal the accept condition (combinational).
- In ADDR, mem_stall SHALL be 1.
- In DATA, mem_stall SHALL be !hready.
- The completion cycle therefore has mem_stall=0.
REQ-021 rdata_valid SHALL be 1 only in DATA with hready=1, hresp=0 and a load.
- rdata SHALL then be the byte or half selected by the registered addr[1:0], extended per unsigned.
- rdata SHALL be 0 otherwise.
REQ-022 exp_bus_err SHALL pulse in DATA when hready=1 && hresp=1.
- rdata_valid SHALL stay 0 in that cycle.
- The FSM SHALL return to IDLE.
- A cycle with hresp=1 and hready=0 SHALL only wait.
REQ-023 exp_misalign SHALL pulse combinationally in IDLE when req_valid && cpu_en && !flush && !aligned.
- No bus transfer and no stall SHALL result.
REQ-024 flush or cpu_en=0 SHALL be ignored in ADDR and DATA; a committed transfer always completes.
REQ-025 A new request SHALL be accepted no earlier than the cycle after completion, i.e. back in IDLE.
- There is no address/data phase overlap.

Reset
REQ-026 On rst_n low, SHALL set state=IDLE, all registered fields=0 and htrans=00 immediately, regardless of clk.
- haddr=0, hwrite=0, hsize=000, hwdata=0.
REQ-027 During reset, SHALL hold mem_stall, rdata_valid, exp_misalign and exp_bus_err at 0 and rdata at 0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no exception pulse.
- After reset release the FSM SHALL start in IDLE.

Verification
REQ-029 Word load: addr=0x100, size=10, hready=1 always.
- Required: htrans=10 one cycle, then stall=0 completion with rdata_valid=1.
- With hrdata=0xDEADBEEF, rdata=0xDEADBEEF; 2 stall cycles total.
REQ-030 Signed byte load: addr=0x103, hrdata=0x80112233 -> rdata=0xFFFFFF80.
- Same access with unsigned=1 -> rdata=0x00000080.
REQ-031 Half store with wait states: addr=0x202, wdata=0x0000ABCD, hready=0 for 3 DATA cycles.
- Required: hsize=001, hwdata=0xABCDABCD held for 3 cycles, mem_stall=1 throughout, dropping on hready=1.
REQ-032 Misaligned word: addr=0x102, size=10.
- Required: exp_misalign=1 same cycle, htrans stays 00, mem_stall=0.
REQ-033 Bus error: in DATA, drive hresp=1 with hready=0, then hresp=1 with hready=1.
- Required: exp_bus_err pulses exactly once, rdata_valid=0, FSM back to IDLE.
REQ-034 Flush and reset: flush=1 with req_valid in IDLE -> no transfer; rst_n low during ADDR -> htrans=00 immediately, no pulses.
